// File: rtl/ps2_scan_controller.sv
// Host-side PS/2 keyboard receiver: oversampled frame capture, E0/F0 prefix folding, event FIFO.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_controller #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    input  logic        ovf_clr,
    output logic        evt_valid,
    output logic [15:0] evt_data,
    output logic        overflow,
    output logic        frame_err
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMax    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TOne    = 1;
    localparam logic [PW-1:0] PtrOne  = 1;
    localparam logic [PW:0]   CntOne  = 1;
    localparam logic [PW:0]   CntFull = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    // Synchronisers reset high so the idle bus never looks like a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   prev_q, fall_q, bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            prev_q     <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            prev_q     <= clk_sync_q[SYNC_STAGES-1];
            fall_q     <= prev_q & ~clk_sync_q[SYNC_STAGES-1];
            bit_q      <= dat_sync_q[SYNC_STAGES-1];
        end
    end

    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    byte_q, byte_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          strobe_q, strobe_d;
    logic          err_q, err_d;
    logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        byte_d   = byte_q;
        tcnt_d   = tcnt_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        frame_ok = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d    = par_q;
`endif
        if (state_q == StIdle || fall_q) begin
            tcnt_d = '0;
        end else if (tcnt_q == TMax) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tcnt_d  = '0;
        end else begin
            tcnt_d = tcnt_q + TOne;
        end

        if (fall_q) begin
            unique case (state_q)
                StIdle: begin
                    if (!bit_q) begin
                        state_d  = StData;
                        bitcnt_d = 3'd0;
                    end
                end
                StData: begin
                    sr_d[bitcnt_q] = bit_q;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                StParity: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = bit_q;
`endif
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
`ifdef PS2_PARITY_CHECK_EN
                    frame_ok = bit_q & (^{sr_q, par_q});
`else
                    frame_ok = bit_q;
`endif
                    if (frame_ok) begin
                        strobe_d = 1'b1;
                        byte_d   = sr_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            sr_q     <= '0;
            byte_q   <= '0;
            tcnt_q   <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            byte_q   <= byte_d;
            tcnt_q   <= tcnt_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q    <= par_d;
`endif
        end
    end

    assign frame_err = err_q;

    // Prefix folding: E0/F0 only arm flags, any other byte becomes one event.
    logic        ext_q, ext_d, brk_q, brk_d, push;
    logic [15:0] push_evt;

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        push     = 1'b0;
        push_evt = {brk_q, ext_q, 6'b0, byte_q};
        if (strobe_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full, pop, wr, drop, ovf_q;

    assign full      = (cnt_q == CntFull);
    assign evt_valid = (cnt_q != '0);
    assign pop       = rd_en & evt_valid;
    assign wr        = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign overflow  = ovf_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr, pop})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= push_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
            cnt_q <= cnt_d;
            if (wr)  wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Randomised bench for ps2_scan_controller against a frame-level event model.
module tb_ps2_scan_controller;

    localparam int FD   = 4;
    localparam int TO   = 400;
    localparam int SS   = 2;
    localparam int HALF = 8;
    localparam int GAP  = 20;

    logic        clk, rst_n, ps2_clk, ps2_data, rd_en, ovf_clr;
    logic        evt_valid, overflow, frame_err;
    logic [15:0] evt_data;

    ps2_scan_controller #(
        .FIFO_DEPTH    (FD),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .evt_valid(evt_valid),
        .evt_data (evt_data),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_cnt = 0;
    int          exp_err = 0;
    logic [15:0] mq[$];
    bit          m_ext, m_brk, m_ovf;

    always @(posedge clk) if (frame_err === 1'b1) err_cnt <= err_cnt + 1;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Event model: what a complete frame should do to the flags and the queue.
    task automatic model_frame(input logic [7:0] b, input bit bad_par);
`ifdef PS2_PARITY_CHECK_EN
        if (bad_par) begin
            exp_err++;
            return;
        end
`endif
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (mq.size() < FD) mq.push_back({m_brk, m_ext, 6'b0, b});
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit chk_lat,
                              input bit rd_pulse);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        // Edge 1 is the first clk edge that sees the stop-bit fall at the pin.
        for (int i = 1; i <= SS + 3; i++) begin
            @(posedge clk);
            #1;
            if (chk_lat && i == SS + 2) check_eq("lat_early", evt_valid, 1'b0);
            if (chk_lat && i == SS + 3) check_eq("lat_valid", evt_valid, 1'b1);
            if (rd_pulse) rd_en = (i == SS + 2);
        end
        rd_en = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(negedge clk);
        if (rd_pulse && mq.size() != 0) void'(mq.pop_front());
        model_frame(b, bad_par);
    endtask

    task automatic pop_one();
        @(negedge clk);
        check_eq("valid", evt_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("data", evt_data, mq[0]);
            rd_en = 1'b1;
            @(negedge clk) rd_en = 1'b0;
            void'(mq.pop_front());
        end
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        @(negedge clk);
        check_eq({tag, "_valid"}, evt_valid, 1'b1);
        check_eq({tag, "_data"}, evt_data, exp);
        rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic clr_ovf();
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int base;
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", evt_valid, 1'b0);
        check_eq("rst_data", evt_data, 16'h0000);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame with latency check, then pop.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        pop_expect("t1", 16'h001C);
        check_eq("t1_empty", evt_valid, 1'b0);

        // Prefix folding.
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        pop_expect("t2a", 16'hC075);
        @(negedge clk) check_eq("t2_one", evt_valid, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        pop_expect("t2b", 16'h0075);

        // Overflow.
        send_frame(8'h15, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0, 1'b0);
        check_eq("t3_no_ovf", overflow, 1'b0);
        send_frame(8'h2C, 1'b0, 1'b0, 1'b0);
        check_eq("t3_ovf", overflow, 1'b1);
        pop_expect("t3a", 16'h0015);
        pop_expect("t3b", 16'h001D);
        pop_expect("t3c", 16'h0024);
        pop_expect("t3d", 16'h002D);
        @(negedge clk) check_eq("t3_empty", evt_valid, 1'b0);
        clr_ovf();
        check_eq("t3_clr", overflow, 1'b0);

        // Timeout of a partial frame.
        base = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TO + 60) @(negedge clk);
        check_eq("t4_err", 16'(err_cnt - base), 16'd1);
        check_eq("t4_noevt", evt_valid, 1'b0);
        exp_err++;
        send_frame(8'h2A, 1'b0, 1'b0, 1'b0);
        pop_expect("t4", 16'h002A);

        // Wrong parity.
        base = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check_eq("t5_err", 16'(err_cnt - base), 16'd1);
        @(negedge clk) check_eq("t5_noevt", evt_valid, 1'b0);
`else
        check_eq("t5_err", 16'(err_cnt - base), 16'd0);
        pop_expect("t5", 16'h001C);
`endif

        // Reset mid-frame drops a queued event and a pending prefix.
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_valid", evt_valid, 1'b0);
        check_eq("t6_data", evt_data, 16'h0000);
        check_eq("t6_ovf", overflow, 1'b0);
        mq.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        pop_expect("t6", 16'h005A);

        // Full FIFO with a pop landing on the push cycle.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b1);
        check_eq("t7_ovf", overflow, 1'b0);
        pop_expect("t7a", 16'h0002);
        pop_expect("t7b", 16'h0003);
        pop_expect("t7c", 16'h0004);
        pop_expect("t7d", 16'h0005);

        // Randomised traffic against the model.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 20) b = 8'hE0;
            else if (r < 35) b = 8'hF0;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
            end
            send_frame(b, $urandom_range(0, 9) == 0, 1'b0, 1'b0);
            check_eq("rnd_ovf", overflow, m_ovf);
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) pop_one();
            end
            if (m_ovf && $urandom_range(0, 1) == 0) clr_ovf();
        end
        while (mq.size() != 0) pop_one();
        @(negedge clk) check_eq("rnd_empty", evt_valid, 1'b0);
        check_eq("err_total", 16'(err_cnt), 16'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_controller.md
Name: ps2_scan_controller

Overview:
Host-side PS/2 keyboard controller in the `clk` domain.
- Oversamples the keyboard's `ps2_clk`/`ps2_data` pins and sequences frame capture with a frame FSM, including timeout recovery.
- Folds E0 (extended) and F0 (break) prefix bytes into single key events.
- Buffers events in a small FIFO that the CPU side drains with a valid/pop handshake.
- Replaces direct sampling on keyboard clock edges; no logic runs on `ps2_clk`.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is aborted.
- SYNC_STAGES, 2: synchroniser flops on `ps2_clk` and `ps2_data`; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw keyboard clock pin.
- ps2_data  in  1  raw keyboard data pin.
- rd_en  in  1  pop the FIFO head; ignored when empty.
- ovf_clr  in  1  clears `overflow`.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  16  FIFO head, first-word-fall-through:
  - [15] = release (a break prefix was seen),
  - [14] = extended (an extended prefix was seen),
  - [13:8] = 0,
  - [7:0] = scancode.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on a bad stop bit, bad parity, or timeout.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; FIFO empty; prefix flags clear; bit counter and timeout counter = 0.
  - Synchroniser flops reset to 1 (idle bus), so no false edge is seen after reset.
  - All outputs 0.
  - Reset mid-frame discards the partial frame and any pending prefixes.
- Edge detect: a fall is `prev`=1 and synced `ps2_clk`=0. Data is sampled from synced `ps2_data` on the same cycle.
- Frame FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: on a fall, data=0 moves to DATA with bitcnt=0. Data=1 is treated as a glitch and FSM stays in IDLE.
  - DATA: each fall shifts data into `sr[bitcnt]`, LSB first. After the 8th bit, move to PARITY.
  - PARITY: latch the parity bit, then move to STOP.
  - STOP: on a fall, move to IDLE. If data=1 (and parity is OK when checked), issue `byte_strobe` for 1 cycle. Otherwise pulse `frame_err` and issue no strobe.
- Timeout:
  - Counter clears on every fall and while in IDLE. It increments in all other states.
  - At TIMEOUT_CYCLES-1: move to IDLE, pulse `frame_err`, discard the partial byte. Prefix flags are kept.
- Prefix decode, on `byte_strobe`:
  - 0xE0 sets `ext_pend`.
  - 0xF0 sets `brk_pend`.
  - Any other byte pushes {`brk_pend`, `ext_pend`, 6'b0, byte} and clears both flags.
  - Repeated prefixes are idempotent.
- FIFO:
  - Push when not full. When full and not popping, the event is dropped and `overflow` is set.
  - Push and pop in the same cycle with the FIFO full: both occur, nothing is dropped.
  - Pop happens on `rd_en` && `evt_valid`; the new head appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; a separate count register distinguishes full from empty.
- overflow:
  - Cleared by `ovf_clr`.
  - If set and clear happen in the same cycle, set wins.
- Latency: `evt_valid` rises SYNC_STAGES+3 `clk` cycles after the first `clk` edge that samples the stop-bit `ps2_clk` fall low at the pin.
  - The extra cycles are: edge detect, strobe, FIFO write.
- Host-to-device transmission is out of scope; pins are input only.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: in STOP, the frame is accepted only if the XOR of the 8 data bits and the parity bit = 1 (odd parity). On failure, pulse `frame_err`, issue no strobe, and leave the prefix flags unchanged.
- Undefined: the parity bit is latched but ignored, and parity-related logic is absent.

Test Plan:
1. Valid frame 0x1C, then idle → `evt_valid`=1 at the specified latency with `evt_data`=0x001C; pulse `rd_en` → `evt_valid`=0 next cycle.
2. Frames E0, F0, 75 → exactly one event, 0xC075. Then frame 75 → 0x0075.
3. FIFO_DEPTH=4, frames 0x15, 0x1D, 0x24, 0x2D, 0x2C with no reads → four events 0x0015..0x002D in order, `overflow`=1, 0x2C lost; `ovf_clr` → `overflow`=0.
4. Start bit plus 4 data bits, then `ps2_clk` held high TIMEOUT_CYCLES cycles → one `frame_err` pulse, no event. A following frame 0x2A → 0x002A.
5. Frame 0x1C with wrong parity bit → with PS2_PARITY_CHECK_EN: `frame_err` pulse, no event; without it: event 0x001C.
6. `rst_n` low after 5 data bits of a frame → outputs 0, FIFO empty. After release, frame 0x5A → 0x005A. Also: with the FIFO full, `rd_en` in the same cycle as a push → no `overflow`, order preserved.
